// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared states, anode slot codes and segment patterns for seg_scan_decoder.
package seg_scan_pkg;
   typedef enum logic [1:0] {BLANK, SETTLE, HELD} scan_state_e;
   localparam logic [3:0] AN_ONES      = 4'b1110;
   localparam logic [3:0] AN_TENS      = 4'b1101;
   localparam logic [3:0] AN_HUNDREDS  = 4'b1011;
   localparam logic [3:0] AN_THOUSANDS = 4'b0111;
   localparam logic [3:0] AN_BLANK     = 4'b1111;
   localparam logic [6:0] SEG_BLANK    = 7'b1111111;
   // Active-low, bit6=g .. bit0=a, indexed by hex digit.
   localparam logic [6:0] SEG_PAT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
endpackage

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// seg7_to_hex: active-low 7-segment pattern to hex digit with a valid flag.
module seg7_to_hex
   import seg_scan_pkg::*;
(
   input  logic [6:0] segs_i,
   output logic [3:0] digit_o,
   output logic       valid_o
);
   always_comb begin
      digit_o = '0;
      valid_o = 1'b0;
      for (int i = 0; i < 16; i++)
         if (segs_i == SEG_PAT[i]) begin
            digit_o = 4'(i);
            valid_o = 1'b1;
         end
   end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes scanned 7-segment anode/segment buses back into a digit frame.
// Define SEG_SCAN_SYNC_EN to pass anode/segs through a 2-flop synchronizer.
module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] anode,
   input  logic [6:0] segs,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic [3:0] hundreds,
   output logic [3:0] thousands,
   output logic       frame_valid,
   output logic       err,
   output logic [7:0] err_count,
   output logic       stale
);
   localparam logic [7:0]  SETTLE_N = 8'(SETTLE_CYCLES);
   localparam logic [31:0] TO_N     = 32'(TIMEOUT_CYCLES);
   logic [3:0] anode_s;
   logic [6:0] segs_s;
`ifdef SEG_SCAN_SYNC_EN
   logic [3:0] an_m_q, an_s_q;
   logic [6:0] sg_m_q, sg_s_q;
   always_ff @(posedge clk)
      if (!reset) begin
         {an_m_q, an_s_q} <= {AN_BLANK, AN_BLANK};
         {sg_m_q, sg_s_q} <= {SEG_BLANK, SEG_BLANK};
      end else begin
         {an_m_q, an_s_q} <= {anode, an_m_q};
         {sg_m_q, sg_s_q} <= {segs, sg_m_q};
      end
   assign anode_s = an_s_q;
   assign segs_s  = sg_s_q;
`else
   assign anode_s = anode;
   assign segs_s  = segs;
`endif
   scan_state_e      state_q, state_d;
   logic [7:0]       cnt_q, cnt_d, err_count_q, err_count_d;
   logic [10:0]      prev_q;
   logic [3:0]       mask_q, mask_d, mask_n;
   logic [3:0][3:0]  shadow_q, shadow_d, dig_q, dig_d;
   logic [31:0]      to_q, to_d;
   logic             fv_q, err_q, stale_q, eval, blank, same, one_low, accept, publish;
   logic [3:0]       digit;
   logic             seg_ok;
   logic [1:0]       pos;
   seg7_to_hex u_dec (.segs_i(segs_s), .digit_o(digit), .valid_o(seg_ok));
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blank   = anode_s == AN_BLANK;
      same    = {anode_s, segs_s} == prev_q;
      case (state_q)
         BLANK:  if (!blank) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                 end
         SETTLE: begin
                    state_d = !same && blank ? BLANK : SETTLE;
                    cnt_d   = same ? cnt_q + 8'd1 : 8'd1;
                 end
         default: if (!same) begin
                    state_d = blank ? BLANK : SETTLE;
                    cnt_d   = 8'd1;
                 end
      endcase
      // A slot is evaluated on the sample that completes the settle run.
      eval = state_d == SETTLE && cnt_d == SETTLE_N;
      if (eval) state_d = HELD;
      one_low  = anode_s inside {AN_ONES, AN_TENS, AN_HUNDREDS, AN_THOUSANDS};
      pos      = anode_s == AN_ONES ? 2'd0 : anode_s == AN_TENS ? 2'd1 :
                 anode_s == AN_HUNDREDS ? 2'd2 : 2'd3;
      accept   = eval && one_low && seg_ok;
      mask_n   = accept ? mask_q | ~anode_s : mask_q;
      publish  = accept && &mask_n[2:0];
      mask_d   = publish ? 4'd0 : mask_n;
      shadow_d = shadow_q;
      if (accept) shadow_d[pos] = digit;
      dig_d       = publish ? shadow_d : dig_q;
      err_count_d = eval && !accept && err_count_q != 8'hFF ? err_count_q + 8'd1 : err_count_q;
      to_d        = accept ? 32'd0 : to_q == TO_N ? to_q : to_q + 32'd1;
   end
   always_ff @(posedge clk)
      if (!reset) begin
         state_q     <= BLANK;
         cnt_q       <= '0;
         prev_q      <= {AN_BLANK, SEG_BLANK};
         mask_q      <= '0;
         shadow_q    <= '0;
         dig_q       <= '0;
         err_count_q <= '0;
         to_q        <= '0;
         fv_q        <= 1'b0;
         err_q       <= 1'b0;
         stale_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prev_q      <= {anode_s, segs_s};
         mask_q      <= mask_d;
         shadow_q    <= shadow_d;
         dig_q       <= dig_d;
         err_count_q <= err_count_d;
         to_q        <= to_d;
         fv_q        <= publish;
         err_q       <= eval && !accept;
         stale_q     <= !accept && to_d == TO_N;
      end
   assign ones        = dig_q[0];
   assign tens        = dig_q[1];
   assign hundreds    = dig_q[2];
   assign thousands   = dig_q[3];
   assign frame_valid = fv_q;
   assign err         = err_q;
   assign err_count   = err_count_q;
   assign stale       = stale_q;
endmodule
